// File: rtl/wb_arbiter2_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arbiter2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    localparam int unsigned BYTE_WIDTH = 8;

    // Number of byte-select lanes for a given data width.
    function automatic int unsigned sel_width(input int unsigned data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Classic Wishbone bus bundle; master drives the request, slave returns ack/read data.
interface wishbone_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import wb_arbiter2_pkg::*;

    localparam int unsigned SEL_WIDTH = sel_width(DATA_WIDTH);

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_w;
    logic [DATA_WIDTH-1:0] dat_r;
    logic                  ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack
    );

endinterface

// File: rtl/wb_rr_grant.sv
// Next-grant decision from the two CYC requests; grant_o = 1 selects master 1.
module wb_rr_grant #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic cyc0_i,
    input  logic cyc1_i,
    input  logic last_grant_i,
    output logic req_valid_o,
    output logic grant_o
);

    always_comb begin
        req_valid_o = cyc0_i | cyc1_i;
        grant_o     = 1'b0;
        if (cyc0_i && cyc1_i) begin
            // On a tie the master that was not served last wins.
            grant_o = FIXED_PRIO ? 1'b0 : ~last_grant_i;
        end else if (cyc1_i) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter in front of a single RAM slave, round-robin on ties.
// Define WB_ARBITER_FIXED_PRIO_EN to make master 0 win every tie instead.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    wishbone_if.slave  m0_if,
    wishbone_if.slave  m1_if,
    wishbone_if.master s_if
);

    localparam int unsigned SEL_WIDTH = sel_width(DATA_WIDTH);

    arb_state_t state_q;
    arb_state_t state_d;

    logic req_valid_c;
    logic grant_c;
    logic last_grant_c;

    logic                  cyc_c;
    logic                  stb_c;
    logic                  we_c;
    logic [SEL_WIDTH-1:0]  sel_c;
    logic [ADDR_WIDTH-1:0] adr_c;
    logic [DATA_WIDTH-1:0] dat_w_c;

`ifdef WB_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;

    assign last_grant_c = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;

    logic last_grant_q;
    logic last_grant_d;

    // Remember the owner that just released the bus.
    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == ARB_GRANT0) && !m0_if.cyc) begin
            last_grant_d = 1'b0;
        end else if ((state_q == ARB_GRANT1) && !m1_if.cyc) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant_c = last_grant_q;
`endif

    wb_rr_grant #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_grant (
        .cyc0_i       (m0_if.cyc),
        .cyc1_i       (m1_if.cyc),
        .last_grant_i (last_grant_c),
        .req_valid_o  (req_valid_c),
        .grant_o      (grant_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ownership changes only through ARB_IDLE, giving one dead cycle per handover.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_valid_c) begin
                    state_d = grant_c ? ARB_GRANT1 : ARB_GRANT0;
                end
            end
            ARB_GRANT0: begin
                if (!m0_if.cyc) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT1: begin
                if (!m1_if.cyc) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Request mux straight off the registered state; idle drives an all-zero request.
    always_comb begin
        cyc_c   = 1'b0;
        stb_c   = 1'b0;
        we_c    = 1'b0;
        sel_c   = '0;
        adr_c   = '0;
        dat_w_c = '0;
        case (state_q)
            ARB_GRANT0: begin
                cyc_c   = m0_if.cyc;
                stb_c   = m0_if.stb;
                we_c    = m0_if.we;
                sel_c   = m0_if.sel;
                adr_c   = m0_if.adr;
                dat_w_c = m0_if.dat_w;
            end
            ARB_GRANT1: begin
                cyc_c   = m1_if.cyc;
                stb_c   = m1_if.stb;
                we_c    = m1_if.we;
                sel_c   = m1_if.sel;
                adr_c   = m1_if.adr;
                dat_w_c = m1_if.dat_w;
            end
            default: begin
            end
        endcase
    end

    assign s_if.cyc   = cyc_c;
    assign s_if.stb   = stb_c;
    assign s_if.we    = we_c;
    assign s_if.sel   = sel_c;
    assign s_if.adr   = adr_c;
    assign s_if.dat_w = dat_w_c;

    // Read data is shared; each master qualifies it with its own ack.
    assign m0_if.ack   = (state_q == ARB_GRANT0) && s_if.ack;
    assign m1_if.ack   = (state_q == ARB_GRANT1) && s_if.ack;
    assign m0_if.dat_r = s_if.dat_r;
    assign m1_if.dat_r = s_if.dat_r;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed scoreboard bench for wb_arbiter2 with a one-wait-state RAM model.
`timescale 1ns/1ps
module tb_wb_arbiter2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wishbone_if m0 ();
    wishbone_if m1 ();
    wishbone_if s  ();

    wb_arbiter2 dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m0_if  (m0),
        .m1_if  (m1),
        .s_if   (s)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          last;
    } xfer_t;

    typedef struct {
        int          owner;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          gap;
        int          lat;
    } exp_t;

    xfer_t q0[$];
    xfer_t q1[$];
    exp_t  exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input bit last);
        xfer_t x;
        x.we = we; x.adr = adr; x.dat = dat; x.last = last;
        return x;
    endfunction

    function automatic void expect_x(input int owner, input logic we, input logic [31:0] adr,
                                     input logic [31:0] dat, input int gap, input int lat);
        exp_t e;
        e.owner = owner; e.we = we; e.adr = adr; e.dat = dat; e.gap = gap; e.lat = lat;
        exp_q.push_back(e);
    endfunction

    // RAM slave model: ack one cycle after a strobe, single-cycle ack pulse.
    logic [31:0] mem [256];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.ack   <= 1'b0;
            s.dat_r <= '0;
        end else begin
            s.ack <= s.cyc && s.stb && !s.ack;
            if (s.cyc && s.stb && !s.ack) begin
                s.dat_r <= mem[s.adr[9:2]];
                if (s.we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s.sel[b]) mem[s.adr[9:2]][8*b +: 8] <= s.dat_w[8*b +: 8];
                    end
                end
            end
        end
    end

    // Monitor: s_low counts negedges with s.cyc low; a handover through one
    // idle state shows 2 (owner's drop cycle plus the idle cycle).
    int   cyc_n = 0, s_low = 0, last_gap = 0, s_rise = 0, m_rise0 = 0, m_rise1 = 0;
    logic s_prev = 1'b0, m0_prev = 1'b0, m1_prev = 1'b0;
    exp_t e;
    int   owner;

    always @(negedge clk) begin
        cyc_n++;
        if (m0.cyc && !m0_prev) m_rise0 = cyc_n;
        if (m1.cyc && !m1_prev) m_rise1 = cyc_n;
        if (s.cyc && !s_prev) begin
            last_gap = s_low;
            s_rise   = cyc_n;
        end
        s_low   = s.cyc ? 0 : s_low + 1;
        s_prev  = s.cyc;
        m0_prev = m0.cyc;
        m1_prev = m1.cyc;
        if (rst_n && (m0.ack || m1.ack)) begin
            chk("ack_exclusive", 64'(m0.ack & m1.ack), 64'd0);
            owner = m1.ack ? 1 : 0;
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 64'(owner), 64'hFF);
            end else begin
                e = exp_q.pop_front();
                chk("owner", 64'(owner), 64'(e.owner));
                chk("adr", 64'(s.adr), 64'(e.adr));
                chk("we", 64'(s.we), 64'(e.we));
                if (e.we) begin
                    chk("dat_w", 64'(s.dat_w), 64'(e.dat));
                    chk("sel", 64'(s.sel), 64'hF);
                end else begin
                    chk("dat_r", 64'(owner == 1 ? m1.dat_r : m0.dat_r), 64'(e.dat));
                end
                if (e.gap >= 0) chk("idle_gap", 64'(last_gap), 64'(e.gap));
                if (e.lat >= 0) chk("grant_lat", 64'(s_rise - (owner == 1 ? m_rise1 : m_rise0)), 64'(e.lat));
            end
        end
    end

    // Drives both masters from q0/q1; master n waits dn cycles before its first request.
    task automatic run_masters(input int d0, input int d1, input int budget);
        bit drop0 = 1'b0;
        bit drop1 = 1'b0;
        int n = 0;
        xfer_t x;
        while ((q0.size() > 0 || q1.size() > 0 || m0.cyc || m1.cyc) && n < budget) begin
            @(posedge clk); #1;
            if (drop0) begin
                m0.cyc = 1'b0; m0.stb = 1'b0; drop0 = 1'b0;
            end else if (q0.size() > 0 && n >= d0) begin
                m0.cyc = 1'b1; m0.stb = 1'b1; m0.we = q0[0].we;
                m0.adr = q0[0].adr; m0.dat_w = q0[0].dat; m0.sel = 4'hF;
            end
            if (drop1) begin
                m1.cyc = 1'b0; m1.stb = 1'b0; drop1 = 1'b0;
            end else if (q1.size() > 0 && n >= d1) begin
                m1.cyc = 1'b1; m1.stb = 1'b1; m1.we = q1[0].we;
                m1.adr = q1[0].adr; m1.dat_w = q1[0].dat; m1.sel = 4'hF;
            end
            @(negedge clk);
            if (m0.cyc && m0.ack && q0.size() > 0) begin
                x = q0.pop_front();
                if (x.last || q0.size() == 0) drop0 = 1'b1;
            end
            if (m1.cyc && m1.ack && q1.size() > 0) begin
                x = q1.pop_front();
                if (x.last || q1.size() == 0) drop1 = 1'b1;
            end
            n++;
        end
        chk("run_done", 64'(q0.size() + q1.size()), 64'd0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        m0.cyc = 1'b0; m0.stb = 1'b0;
        m1.cyc = 1'b0; m1.stb = 1'b0;
    endtask

    initial begin
        // Reset with both masters already requesting.
        rst_n = 1'b0;
        m0.cyc = 1'b1; m0.stb = 1'b1; m0.we = 1'b1; m0.sel = 4'hF;
        m0.adr = 32'h100; m0.dat_w = 32'h1111_1111;
        m1.cyc = 1'b1; m1.stb = 1'b1; m1.we = 1'b1; m1.sel = 4'hF;
        m1.adr = 32'h104; m1.dat_w = 32'h2222_2222;
        repeat (3) begin
            @(negedge clk);
            chk("rst_s_cyc", 64'(s.cyc), 64'd0);
            chk("rst_s_stb", 64'(s.stb), 64'd0);
            chk("rst_s_adr", 64'(s.adr), 64'd0);
            chk("rst_m0_ack", 64'(m0.ack), 64'd0);
            chk("rst_m1_ack", 64'(m1.ack), 64'd0);
        end
        q0.push_back(mk(1'b1, 32'h100, 32'h1111_1111, 1'b1));
        q1.push_back(mk(1'b1, 32'h104, 32'h2222_2222, 1'b1));
        expect_x(0, 1'b1, 32'h100, 32'h1111_1111, -1, -1);
        expect_x(1, 1'b1, 32'h104, 32'h2222_2222, 2, -1);
        rst_n = 1'b1;
        run_masters(0, 0, 200);

        // Persistent ties: one write per bus cycle from each master, four rounds.
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b1, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1));
            q1.push_back(mk(1'b1, 32'h80 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1));
        end
`ifdef WB_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            expect_x(0, 1'b1, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), (i == 0) ? -1 : 2, (i == 0) ? 1 : -1);
        for (int i = 0; i < 4; i++)
            expect_x(1, 1'b1, 32'h80 + 32'(4 * i), 32'hB000_0000 + 32'(i), 2, -1);
`else
        for (int i = 0; i < 4; i++) begin
            expect_x(0, 1'b1, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), (i == 0) ? -1 : 2, (i == 0) ? 1 : -1);
            expect_x(1, 1'b1, 32'h80 + 32'(4 * i), 32'hB000_0000 + 32'(i), 2, -1);
        end
`endif
        run_masters(0, 0, 400);

        // m1 holds the bus for three writes while m0 waits.
        q1.push_back(mk(1'b1, 32'h0, 32'hC000_0000, 1'b0));
        q1.push_back(mk(1'b1, 32'h4, 32'hC000_0001, 1'b0));
        q1.push_back(mk(1'b1, 32'h8, 32'hC000_0002, 1'b1));
        q0.push_back(mk(1'b1, 32'h14, 32'hD000_0000, 1'b1));
        expect_x(1, 1'b1, 32'h0, 32'hC000_0000, -1, 1);
        expect_x(1, 1'b1, 32'h4, 32'hC000_0001, -1, -1);
        expect_x(1, 1'b1, 32'h8, 32'hC000_0002, -1, -1);
        expect_x(0, 1'b1, 32'h14, 32'hD000_0000, 2, -1);
        run_masters(1, 0, 200);

        // Single master 0 write then read-back.
        q0.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1));
        q0.push_back(mk(1'b0, 32'h10, 32'h0, 1'b1));
        expect_x(0, 1'b1, 32'h10, 32'hDEAD_BEEF, -1, 1);
        expect_x(0, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1);
        run_masters(0, 0, 200);

        // Master 1 reads back data written by both masters.
        q1.push_back(mk(1'b0, 32'h4, 32'h0, 1'b1));
        q1.push_back(mk(1'b0, 32'h14, 32'h0, 1'b1));
        expect_x(1, 1'b0, 32'h4, 32'hC000_0001, -1, 1);
        expect_x(1, 1'b0, 32'h14, 32'hD000_0000, 2, 1);
        run_masters(0, 0, 200);

        // Asynchronous reset while master 1 owns the bus with STB high.
        repeat (2) @(posedge clk);
        #1;
        m1.cyc = 1'b1; m1.stb = 1'b1; m1.we = 1'b1; m1.adr = 32'h20; m1.dat_w = 32'h5555_5555;
        @(negedge clk);
        chk("async_pre_grant_cyc", 64'(s.cyc), 64'd0);
        @(negedge clk);
        chk("async_grant_cyc", 64'(s.cyc), 64'd1);
        chk("async_grant_stb", 64'(s.stb), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", 64'(s.cyc), 64'd0);
        chk("async_rst_stb", 64'(s.stb), 64'd0);
        chk("async_rst_m1_ack", 64'(m1.ack), 64'd0);
        @(negedge clk);
        m1.cyc = 1'b0; m1.stb = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_cyc", 64'(s.cyc), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter placed directly upstream of the Wishbone RAM slave (wb_xpm_ram). Both masters share the single RAM port through it, for example a CPU data port and a DMA/loader engine. It grants exactly one master per bus cycle (CYC), muxes that master's request signals onto the slave, and routes ACK and read data back. Arbitration is round-robin by default; fixed priority is available as a compile-time option.

## Interface
Parameters:
- ADDR_WIDTH, 32: address width of all three Wishbone ports.
- DATA_WIDTH, 32: data width; SEL width is DATA_WIDTH/8.

Ports:
- clk_i  input  1  system clock; every register in the block is clocked on its rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- m0_if  wishbone_if.slave  -  master 0 request port. Wins the first tie after reset.
- m1_if  wishbone_if.master-side request port, connected as wishbone_if.slave  -  master 1 request port.
- s_if  wishbone_if.master  -  toward the RAM slave.

Clocking: one clock, clk_i. Reset: asynchronous, active-low, rst_ni. Both are fixed.

## Operation
- State machine with three states: ARB_IDLE, ARB_GRANT0, ARB_GRANT1.
- ARB_IDLE:
  - No master's CYC asserted: stay in ARB_IDLE.
  - Exactly one master's CYC asserted: go to that master's GRANT state.
  - Both asserted: the master not in last_grant wins.
- ARB_GRANTn:
  - s_if CYC, STB, WE, SEL, ADR and write data are taken from master n.
  - ACK from s_if goes only to master n. The other master's ACK is held at 0.
  - Read data from s_if is broadcast to both masters. It is valid only alongside that master's own ACK.
  - While master n holds CYC, the grant is kept, even across several STB/ACK transfers. There is no preemption and no interleaving.
  - When master n drops CYC: return to ARB_IDLE and set last_grant := n.
- Grant changes only pass through ARB_IDLE, which guarantees one dead cycle between owners.
- In ARB_IDLE, s_if CYC and STB are 0 and both master ACKs are 0.
- Reset values:
  - state = ARB_IDLE.
  - last_grant = 1, so master 0 wins the first tie.
  - s_if CYC/STB/WE = 0.
  - s_if SEL/ADR/write data = 0.
  - m0/m1 ACK = 0.
- Reset asserted mid-transfer: the state returns to ARB_IDLE without waiting for a clock edge, and s_if CYC/STB drop immediately. Transfers in flight are lost. Masters must reissue them after reset.
- A master that asserts STB without holding the grant is stalled, because it receives no ACK. No ERR is generated.

## Timing
- Arbitration latency:
  - A CYC first sampled high at rising edge k changes state at edge k.
  - The request appears on s_if during cycle k (after edge k).
  - For an idle bus, that is one cycle from CYC assertion to slave visibility.
- Per-transfer latency after grant: zero added cycles. The request mux and the ACK/data return path are combinational from the registered state.
- Handover: master A drops CYC, one cycle in ARB_IDLE, then the earliest grant to master B.
- Persistent simultaneous requests are served in grant order 0, 1, 0, 1, …

## Configuration
- WB_ARBITER_FIXED_PRIO_EN:
  - Defined: master 0 always wins ties in ARB_IDLE. last_grant is not implemented, and master 1 is served only when master 0's CYC is low in ARB_IDLE.
  - Undefined: round-robin behaviour as described above.

## Structure
- The shared Wishbone package holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_GRANT0, ARB_GRANT1};
  - the SEL-width function DATA_WIDTH/8.
- Sub-module wb_rr_grant: a combinational next-grant decision from the two CYC inputs, last_grant and the priority mode. The top module holds the state, the last_grant register and the muxes.

## Test plan
- Reset:
  - Stimulus: rst_ni = 0 with both masters' CYC/STB high.
  - Required: s_if CYC = 0 and both ACKs = 0 throughout reset. After release, m0 is granted first.
- Single master 0:
  - Stimulus: m0 writes 'hDEADBEEF to address 'h10 with SEL 4'b1111, then reads 'h10.
  - Required: s_if CYC is high one cycle after m0's CYC. The read returns 'hDEADBEEF. m1 ACK stays 0 throughout.
- Tie, round-robin:
  - Stimulus: both masters hold CYC for one write each, repeated 4 times.
  - Required: grant order 0, 1, 0, 1, with exactly one ARB_IDLE cycle between grants.
- Held grant:
  - Stimulus: m1 keeps CYC across 3 writes (addresses 'h0, 'h4, 'h8) while m0 requests.
  - Required: m0 receives no ACK until m1 drops CYC. m0 is granted one cycle after ARB_IDLE.
- Async reset mid-transfer:
  - Stimulus: drop rst_ni between clock edges while in ARB_GRANT1 with STB high.
  - Required: s_if CYC/STB go to 0 before the next clock edge.
- With WB_ARBITER_FIXED_PRIO_EN:
  - Stimulus: persistent simultaneous requests.
  - Required: m0 is granted every time. m1 is granted only when m0's CYC is low.
